fpga_vme_regs: RTL and testbench

- FPGA-side responder for the CPLD-to-FPGA register strobe interface.
- Decodes read and write strobes (FRS/FWS) and the 5-bit word address (FA) issued by the CPLD VME front-end, and services a 32-word register space.
- Returns active-low FDTACK, which the CPLD passes straight through as VME DTACK.
- Exports 16 read/write control registers with per-register write pulses; imports 15 read-only status words plus a firmware version word.

---
 rtl/fpga_vme_regs_if.sv | 21 ++
 rtl/fpga_vme_regs.sv | 148 ++++++++++++++
 tb/tb_fpga_vme_regs.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_vme_regs_if.sv
// CPLD-to-FPGA register strobe bus.
// The CPLD drives strobes, address and write data; the FPGA answers.
interface fpga_vme_regs_if;
    logic        FRS;
    logic        FWS;
    logic [4:0]  FA;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        DOE;
    logic        FDTACK;

    modport master (
        output FRS, FWS, FA, DIN,
        input  DOUT, DOE, FDTACK
    );

    modport slave (
        input  FRS, FWS, FA, DIN,
        output DOUT, DOE, FDTACK
    );
endinterface

// File: rtl/fpga_vme_regs.sv
// FPGA-side register responder for the CPLD VME strobe bus.
// 16 RW words, 15 RO status words and a firmware version word.
module fpga_vme_regs #(
    parameter int unsigned ACK_DELAY  = 2,
    parameter logic [31:0] FW_VERSION = 32'h0103_0000,
    parameter logic [31:0] RW_INIT    = 32'h0000_0000
) (
    input  logic         SYSCLK,
    input  logic         RST_N,
    fpga_vme_regs_if.slave bus,
    output logic [511:0] REG_OUT,
    output logic [15:0]  WR_PULSE,
    input  logic [479:0] RO_IN
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACK_DELAY - 1);

    logic        frs_q, fws_q, frs_d, fws_d;
    logic [4:0]  fa_q;
    logic [31:0] din_q;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  addr_q;
    logic        wr_q;
    logic [31:0] dout_q;
    logic [15:0] wr_pulse_q;
    logic [31:0] rw_q [16];

    logic        rise, accept, sel, fire, fire_wr;
    logic [4:0]  fire_addr;
    logic [31:0] rd_data;

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            frs_q <= 1'b0;
            fws_q <= 1'b0;
            frs_d <= 1'b0;
            fws_d <= 1'b0;
            fa_q  <= '0;
            din_q <= '0;
        end else begin
            frs_q <= bus.FRS;
            fws_q <= bus.FWS;
            frs_d <= frs_q;
            fws_d <= fws_q;
            fa_q  <= bus.FA;
            din_q <= bus.DIN;
        end
    end

    // Simultaneous strobes are illegal and never accepted.
    assign rise   = (frs_q & ~frs_d) | (fws_q & ~fws_d);
    assign accept = rise & ~(frs_q & fws_q);
    assign sel    = wr_q ? fws_q : frs_q;

    // The accept cycle itself is the last wait cycle when ACK_DELAY is 1.
    assign fire_addr = (state_q == S_IDLE) ? fa_q : addr_q;
    assign fire_wr   = (state_q == S_IDLE) ? fws_q : wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = CNT_INIT;
                    if (ACK_DELAY <= 1) begin
                        state_d = S_ACK;
                        fire    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!sel) begin
                    state_d = S_RELEASE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (!sel) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data = FW_VERSION;
        unique case (1'b1)
            !fire_addr[4]:
                rd_data = rw_q[fire_addr[3:0]];
            fire_addr[4] && (fire_addr != 5'd31):
                rd_data = RO_IN[{fire_addr[3:0], 5'd0} +: 32];
            default: ;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < 16; i++) rw_q[i] <= RW_INIT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= '0;
            if (state_q == S_IDLE && accept) begin
                addr_q <= fa_q;
                wr_q   <= fws_q;
            end
            if (fire && fire_wr && !fire_addr[4]) begin
                rw_q[fire_addr[3:0]]       <= din_q;
                wr_pulse_q[fire_addr[3:0]] <= 1'b1;
            end
            if (fire && !fire_wr) dout_q <= rd_data;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = rw_q[g];
    end

    assign WR_PULSE   = wr_pulse_q;
    assign bus.DOUT   = dout_q;
    assign bus.DOE    = (state_q == S_ACK) && !wr_q;
    assign bus.FDTACK = !((state_q == S_ACK) && sel);

endmodule

// File: tb/tb_fpga_vme_regs.sv
// Scoreboard bench for fpga_vme_regs: stimulus queues expected
// acknowledges, a monitor checks each FDTACK assertion against them.
module tb_fpga_vme_regs;

    logic         SYSCLK;
    logic         RST_N;
    logic [511:0] REG_OUT;
    logic [15:0]  WR_PULSE;
    logic [479:0] RO_IN;

    fpga_vme_regs_if bus ();

    fpga_vme_regs dut (
        .SYSCLK  (SYSCLK),
        .RST_N   (RST_N),
        .bus     (bus),
        .REG_OUT (REG_OUT),
        .WR_PULSE(WR_PULSE),
        .RO_IN   (RO_IN)
    );

    typedef struct {
        bit          rd;
        logic [31:0] d;
        logic [15:0] pulse;
        int          t0;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] model [16];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        prev_dtack = 1'b1;

    initial SYSCLK = 1'b0;
    always #15 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [511:0] act,
                         input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] model_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    // Monitor: every falling FDTACK must match a queued expectation.
    always @(negedge SYSCLK) begin
        if (prev_dtack && !bus.FDTACK) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got FDTACK=0 expected 1");
            end else begin
                mon_e = q.pop_front();
                check("latency", cyc - mon_e.t0, 3);
                check("doe", bus.DOE, mon_e.rd);
                if (mon_e.rd) check("dout", bus.DOUT, mon_e.d);
                check("wr_pulse", WR_PULSE, mon_e.pulse);
            end
        end
        prev_dtack = bus.FDTACK;
    end

    task automatic expect_ack(input bit rd, input logic [4:0] a,
                              input logic [31:0] d);
        exp_t e;
        e.rd    = rd;
        e.d     = d;
        e.pulse = (!rd && a < 5'd16) ? (16'd1 << a[3:0]) : 16'd0;
        e.t0    = cyc;
        q.push_back(e);
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge SYSCLK);
            got = !bus.FDTACK;
        end
        check("ack_seen", got, 1);
        if (!got && q.size() != 0) q.delete(q.size() - 1);
    endtask

    task automatic access(input bit rd, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] exp_d);
        bit got;
        @(negedge SYSCLK);
        bus.FA  = a;
        bus.DIN = d;
        if (rd) bus.FRS = 1'b1;
        else    bus.FWS = 1'b1;
        expect_ack(rd, a, exp_d);
        if (!rd && a < 5'd16) model[a[3:0]] = d;
        wait_ack(got);
        bus.DIN = ~d;
        repeat (2) begin
            @(negedge SYSCLK);
            check("ack_hold", bus.FDTACK, 0);
            check("pulse_once", WR_PULSE, 0);
            if (rd) check("dout_stable", bus.DOUT, exp_d);
        end
        bus.FRS = 1'b0;
        bus.FWS = 1'b0;
        @(negedge SYSCLK);
        check("ack_release", bus.FDTACK, 1);
        @(negedge SYSCLK);
        check("doe_release", bus.DOE, 0);
        check("reg_out", REG_OUT, model_vec());
    endtask

    initial begin
        bit got;
        RST_N   = 1'b0;
        bus.FRS = 1'b0;
        bus.FWS = 1'b0;
        bus.FA  = '0;
        bus.DIN = '0;
        RO_IN   = '0;
        for (int i = 0; i < 15; i++)
            RO_IN[32*i +: 32] = 32'h5000_0000 + 32'(i);
        RO_IN[32*4 +: 32]  = 32'hCAFE_0001;
        RO_IN[32*14 +: 32] = 32'h3030_3030;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        repeat (3) @(negedge SYSCLK);
        check("rst_fdtack", bus.FDTACK, 1);
        check("rst_doe", bus.DOE, 0);
        check("rst_dout", bus.DOUT, 0);
        check("rst_pulse", WR_PULSE, 0);
        check("rst_regs", REG_OUT, model_vec());
        RST_N = 1'b1;
        repeat (2) @(negedge SYSCLK);

        access(1, 5'd31, 32'h0, 32'h0103_0000);
        access(0, 5'd5, 32'hDEAD_BEEF, 32'h0);
        access(1, 5'd5, 32'h0, 32'hDEAD_BEEF);
        access(0, 5'd20, 32'h1234_5678, 32'h0);
        access(1, 5'd20, 32'h0, 32'hCAFE_0001);
        access(1, 5'd16, 32'h0, 32'h5000_0000);
        access(1, 5'd30, 32'h0, 32'h3030_3030);
        access(0, 5'd31, 32'h7777_7777, 32'h0);
        access(1, 5'd31, 32'h0, 32'h0103_0000);
        access(0, 5'd15, 32'hA5A5_5A5A, 32'h0);
        access(0, 5'd0, 32'h0000_0001, 32'h0);
        access(1, 5'd15, 32'h0, 32'hA5A5_5A5A);
        access(1, 5'd0, 32'h0, 32'h0000_0001);

        // Both strobes at once: must be ignored entirely.
        @(negedge SYSCLK);
        bus.FA  = 5'd2;
        bus.DIN = 32'h2222_2222;
        bus.FRS = 1'b1;
        bus.FWS = 1'b1;
        repeat (20) begin
            @(negedge SYSCLK);
            check("both_fdtack", bus.FDTACK, 1);
            check("both_doe", bus.DOE, 0);
        end
        check("both_regs", REG_OUT, model_vec());
        bus.FRS = 1'b0;
        bus.FWS = 1'b0;
        repeat (3) @(negedge SYSCLK);

        // Write strobe dropped inside WAIT: aborted.
        @(negedge SYSCLK);
        bus.FA  = 5'd3;
        bus.DIN = 32'h0BAD_0BAD;
        bus.FWS = 1'b1;
        @(negedge SYSCLK);
        bus.FWS = 1'b0;
        repeat (8) begin
            @(negedge SYSCLK);
            check("abort_fdtack", bus.FDTACK, 1);
            check("abort_pulse", WR_PULSE, 0);
        end
        check("abort_regs", REG_OUT, model_vec());
        access(0, 5'd3, 32'h3333_3333, 32'h0);
        access(1, 5'd3, 32'h0, 32'h3333_3333);

        // Reset asserted during ACK of an already committed write.
        @(negedge SYSCLK);
        bus.FA  = 5'd7;
        bus.DIN = 32'h0000_00FF;
        bus.FWS = 1'b1;
        expect_ack(0, 5'd7, 32'h0);
        model[7] = 32'h0000_00FF;
        wait_ack(got);
        check("commit_w7", REG_OUT, model_vec());
        #3;
        RST_N = 1'b0;
        #1;
        check("async_fdtack", bus.FDTACK, 1);
        check("async_doe", bus.DOE, 0);
        check("async_pulse", WR_PULSE, 0);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        check("async_regs", REG_OUT, model_vec());
        bus.FWS = 1'b0;
        @(negedge SYSCLK);
        RST_N = 1'b1;
        repeat (2) @(negedge SYSCLK);
        access(1, 5'd7, 32'h0, 32'h0);
        access(1, 5'd5, 32'h0, 32'h0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge SYSCLK);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
